// File: rtl/byte_serial_adder.sv
// rtl/byte_serial_adder.sv - multi-cycle N-byte adder built around one 8-bit ripple-carry adder
//
// Purpose: latches wide operands on start, adds them one byte per clock
// (least-significant byte first) through a single 8-bit adder with a
// registered carry, then presents the wide sum with a one-cycle done pulse.
//
// Optional feature macro: BYTE_SERIAL_ADDER_SUB_EN
//   Adds input port sub; when sub=1 at the accepted start the block computes
//   A-B mod 2^W (B inverted, carry-in forced to 1), C_out=1 meaning no borrow.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   A, B   in   W-bit operands, captured on accepted start
//   C_in   in   carry into byte 0, captured on accepted start
//   sub    in   (macro only) subtract select, captured on accepted start
//   busy   out  high while an operation is running or completing
//   done   out  one-cycle pulse when S/C_out are updated
//   S      out  W-bit registered sum
//   C_out  out  registered carry out of the top byte

module byte_ripple_add8 (
    output logic       cout,
    output logic [7:0] s,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin
);
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[8];
endmodule

module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    input  logic                  C_in,
`ifdef BYTE_SERIAL_ADDER_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   S,
    output logic                  C_out
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   res;
    logic           cy;
    logic [IW-1:0]  idx;

    logic [7:0]     sum8;
    logic           cout8;
    logic [W-1:0]   res_next;
    logic [W+7:0]   res_ext;
    logic [W-1:0]   b_load;
    logic           cy_load;

    byte_ripple_add8 u_add8 (
        .cout (cout8),
        .s    (sum8),
        .a    (op_a[7:0]),
        .b    (op_b[7:0]),
        .cin  (cy)
    );

    // New sum byte enters at the top; after NBYTES shifts byte 0 sits at the
    // bottom. Widening first keeps this valid for NBYTES=1.
    assign res_ext  = {sum8, res};
    assign res_next = res_ext[W+7:8];

    always_comb begin
        b_load  = B;
        cy_load = C_in;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load  = ~B;
            cy_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cy    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            C_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= A;
                        op_b  <= b_load;
                        cy    <= cy_load;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res  <= res_next;
                    op_a <= op_a >> 8;
                    op_b <= op_b >> 8;
                    cy   <= cout8;
                    idx  <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        S     <= res_next;
                        C_out <= cout8;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here: no queuing.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb/tb_byte_serial_adder.sv - self-checking bench for byte_serial_adder
module tb_byte_serial_adder;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  s;
    logic          c_out;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
    logic          sub;
`endif

    byte_serial_adder #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .C_in  (c_in),
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (s),
        .C_out (c_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Last result the bench expects S/C_out to be holding.
    logic [W-1:0] held_s;
    logic         held_c;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic         vsub;
        int           extra_at;
        logic [W-1:0] exp_s;
        logic         exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, subtraction as A + ~B + 1.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
        logic [W:0] r;
        if (msub)
            r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        else
            r = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
        return r;
    endfunction

    // Runs one operation; start is sampled at "edge 0". If extra_at>0 a
    // second start with A=B=0x11111111 is sampled at edge extra_at+1.
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic ocin, input logic osub, input int extra_at,
                          input logic [W-1:0] es, input logic ec);
        int lat;
        int ndone;
        int nbusy;
        logic [W-1:0] got_s;
        logic got_c;
        lat = -1; ndone = 0; nbusy = 0; got_s = '0; got_c = 1'b0;
        @(negedge clk);
        a = oa; b = ob; c_in = ocin; start = 1'b1;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        sub = osub;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom);
        if (busy) nbusy++;
        for (int k = 1; k <= NB + 6; k++) begin
            if (k == extra_at) begin
                a = 32'h1111_1111; b = 32'h1111_1111; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; got_s = s; got_c = c_out;
                end
            end else if (lat < 0) begin
                check({tag, "_hold_s"}, s, held_s);
                check({tag, "_hold_c"}, c_out, held_c);
            end
            if (!busy) break;
        end
        check({tag, "_latency"}, lat, NB);
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_busy_cycles"}, nbusy, NB + 1);
        check({tag, "_s"}, got_s, es);
        check({tag, "_c"}, got_c, ec);
        check({tag, "_s_after"}, s, es);
        held_s = es;
        held_c = ec;
    endtask

    initial begin
        logic [W:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        logic rsub;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        held_s = '0; held_c = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", s, 0);
        check("rst_c", c_out, 0);
        @(negedge clk); rst_n = 1'b1;

        vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 32'h0000_0100, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1, 32'hACF1_3568, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 32'h8000_0000, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, 1'b1});
`ifdef BYTE_SERIAL_ADDER_SUB_EN
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 0, 32'h0000_0002, 1'b1});
        vecs.push_back('{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 0, 32'h0000_0000, 1'b1});
`endif

        // Consecutive entries start on the first idle cycle: back-to-back.
        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin,
                   vecs[i].vsub, vecs[i].extra_at, vecs[i].exp_s, vecs[i].exp_c);

        // Reset while RUN has idx=2: everything clears at once, no done.
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0102_0304; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_s", s, 0);
        check("midrst_c", c_out, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        held_s = '0; held_c = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int k = 0; k < NB + 3; k++) begin
                @(posedge clk); #1;
                if (done || busy) stray++;
            end
            check("midrst_no_done", stray, 0);
        end
        run_op("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 0, 32'h0000_0031, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            if (i % 6 == 0) rb = ~ra;
`ifdef BYTE_SERIAL_ADDER_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            m = model(ra, rb, rc, rsub);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rsub, 0, m[W-1:0], m[W]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
